// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: size encodings, FSM
// states, the latched request record and the byte-to-word address helper.
package lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_ILL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic            we;
        logic [1:0]      size;
        logic            uns;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } req_t;

    function automatic logic [XLEN-1:0] word_idx(input logic [XLEN-1:0] a);
        return {2'b00, a[XLEN-1:2]};
    endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU request/response and RAM port bundle of the load/store unit.
// slave = the unit itself, master = the surrounding CPU/RAM environment.
interface lsu_if #(parameter int XLEN = lsu_pkg::XLEN);

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    logic            ram_we;
    logic [XLEN-1:0] ram_addr;
    logic [XLEN-1:0] ram_wdata;
    logic [XLEN-1:0] ram_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension, store merge into the
// RAM word, and misalignment detection (trapping only with LSU_MISALIGN_TRAP_EN).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]      size,
    input  logic [1:0]      off,
    input  logic            uns,
    input  logic [XLEN-1:0] word,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_val,
    output logic [XLEN-1:0] merged,
    output logic            misalign
);

    logic [1:0]  eoff;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Effective offset: half and word accesses are aligned down
    always_comb begin
        case (size)
            SZ_H:    eoff = {off[1], 1'b0};
            SZ_W:    eoff = 2'b00;
            default: eoff = off;
        endcase
    end

    assign byte_v = word[{eoff, 3'b000} +: 8];
    assign half_v = eoff[1] ? word[31:16] : word[15:0];

    always_comb begin
        case (size)
            SZ_B:    load_val = uns ? {{(XLEN-8){1'b0}}, byte_v}
                                    : {{(XLEN-8){byte_v[7]}}, byte_v};
            SZ_H:    load_val = uns ? {{(XLEN-16){1'b0}}, half_v}
                                    : {{(XLEN-16){half_v[15]}}, half_v};
            default: load_val = word;
        endcase
    end

    for (genvar k = 0; k < XLEN/8; k++) begin : g_lane
        localparam logic [1:0] LANE = 2'(k);
        logic       sel;
        logic [7:0] src;

        always_comb begin
            sel = 1'b0;
            src = wdata[8*k +: 8];
            case (size)
                SZ_B: begin
                    sel = (eoff == LANE);
                    src = wdata[7:0];
                end
                SZ_H: begin
                    sel = (eoff[1] == LANE[1]);
                    src = wdata[8*(k%2) +: 8];
                end
                SZ_W:    sel = 1'b1;
                default: sel = 1'b0;
            endcase
        end

        assign merged[8*k +: 8] = sel ? src : word[8*k +: 8];
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((size == SZ_H) && off[0]) ||
                      ((size == SZ_W) && (off != 2'b00));
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of a word-addressed RAM; sub-word stores are done
// as read-modify-write. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module lsu #(
    parameter int XLEN = lsu_pkg::XLEN
) (
    input logic  clk,
    input logic  reset,
    lsu_if.slave bus
);
    import lsu_pkg::*;

    state_t          state, state_nxt;
    req_t            rq;
    logic [XLEN-1:0] word_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic            accept;
    logic            bad_req;
    logic [1:0]      a_size;
    logic [1:0]      a_off;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] merged;
    logic            misalign;

    assign accept = bus.req_valid && (state == ST_IDLE);

    // In IDLE the aligner looks at the live request to flag misalignment
    assign a_size  = (state == ST_IDLE) ? bus.req_size      : rq.size;
    assign a_off   = (state == ST_IDLE) ? bus.req_addr[1:0] : rq.addr[1:0];
    assign bad_req = (bus.req_size == SZ_ILL) || misalign;

    lsu_align u_align (
        .size     (a_size),
        .off      (a_off),
        .uns      (rq.uns),
        .word     (bus.ram_rdata),
        .wdata    (rq.wdata),
        .load_val (load_val),
        .merged   (merged),
        .misalign (misalign)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bad_req)                state_nxt = ST_RESP;
                    else if (!bus.req_we)       state_nxt = ST_RD;
                    else if (bus.req_size == SZ_W) state_nxt = ST_WR;
                    else                        state_nxt = ST_RD;
                end
            end
            ST_RD:   state_nxt = ST_CAP;
            ST_CAP:  state_nxt = rq.we ? ST_WR : ST_RESP;
            ST_WR:   state_nxt = ST_RESP;
            ST_RESP: if (bus.resp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rq      <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rq.we    <= bus.req_we;
                        rq.size  <= bus.req_size;
                        rq.uns   <= bus.req_unsigned;
                        rq.addr  <= bus.req_addr;
                        rq.wdata <= bus.req_wdata;
                        word_q   <= bus.req_wdata;
                        rdata_q  <= '0;
                        err_q    <= bad_req;
                    end
                end
                ST_CAP: begin
                    if (rq.we) word_q  <= merged;
                    else       rdata_q <= load_val;
                end
                default: ;
            endcase
        end
    end

    // ram_we decodes straight from state so reset removes it asynchronously
    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.ram_we     = (state == ST_WR);
    assign bus.ram_addr   = word_idx(rq.addr);
    assign bus.ram_wdata  = word_q;

endmodule
